// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
//   Shared definitions for the MM:SS stopwatch core:
//     - state_t      : 2-bit mode encoding (RUN / PAUSED / ADJUST)
//     - DIGIT_W      : width of one BCD digit
//     - DEFAULT_MAX_*: default terminal minute/second values
//     - to_bcd()     : converts a 0..99 integer into a two-digit BCD byte
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PAUSED = 2'd1,
        ST_ADJUST = 2'd2
    } state_t;

    localparam int DIGIT_W         = 4;
    localparam int DEFAULT_MAX_MIN = 59;
    localparam int DEFAULT_MAX_SEC = 59;

    // Two-digit BCD encoding of an integer in 0..99 ({tens, ones}).
    function automatic logic [2*DIGIT_W-1:0] to_bcd(input int v);
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
        tens = DIGIT_W'(v / 10);
        ones = DIGIT_W'(v % 10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd.sv
// bcd_mod_counter
//   Two-digit BCD counter that wraps from max_i back to 00.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     inc_i        : advance by one (ignored when clr_i is high)
//     clr_i        : synchronous clear to 00, highest priority
//     max_i        : terminal value as two BCD digits {tens, ones}
//     tens_o/ones_o: current BCD digits
//     at_max_o     : registered flag, high while the value equals max_i
module bcd_mod_counter
    import stopwatch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 clr_i,
    input  logic [2*DIGIT_W-1:0] max_i,
    output logic [DIGIT_W-1:0]   tens_o,
    output logic [DIGIT_W-1:0]   ones_o,
    output logic                 at_max_o
);

    logic [DIGIT_W-1:0] tens_q, tens_d;
    logic [DIGIT_W-1:0] ones_q, ones_d;
    logic               at_max_q, at_max_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (clr_i) begin
            tens_d = '0;
            ones_d = '0;
        end else if (inc_i) begin
            if (at_max_q) begin
                tens_d = '0;
                ones_d = '0;
            end else if (ones_q == DIGIT_W'(9)) begin
                ones_d = '0;
                tens_d = tens_q + DIGIT_W'(1);
            end else begin
                ones_d = ones_q + DIGIT_W'(1);
            end
        end
        // Track the terminal value alongside the digits so the wrap and the
        // minute carry decisions come straight from a flop.
        at_max_d = ({tens_d, ones_d} == max_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q   <= '0;
            ones_q   <= '0;
            at_max_q <= 1'b0;
        end else begin
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            at_max_q <= at_max_d;
        end
    end

    assign tens_o   = tens_q;
    assign ones_o   = ones_q;
    assign at_max_o = at_max_q;

endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core
//   MM:SS stopwatch driven by divider enable pulses and debounced buttons.
//   Modes: RUN (counts on tick_1hz), PAUSED (holds), ADJUST (tick_2hz bumps
//   the field picked by sel, tick_4hz blinks it).
//   Build option: define STOPWATCH_SATURATE_EN to make RUN hold at
//   MAX_MIN:MAX_SEC instead of wrapping to 00:00.
//   Ports:
//     clk_100mhz, rst_n              : clock, asynchronous active-low reset
//     tick_1hz/tick_2hz/tick_4hz     : single-cycle rate enables
//     pause_pulse, clear_pulse       : single-cycle button pulses
//     adj, sel                       : adjust-mode level, field select (1=sec)
//     min_tens..sec_ones             : BCD digits (registered)
//     running                        : high while in RUN
//     blank_min, blank_sec           : blink blanking for the display
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = DEFAULT_MAX_MIN,
    parameter int MAX_SEC = DEFAULT_MAX_SEC
) (
    input  logic               clk_100mhz,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               tick_4hz,
    input  logic               pause_pulse,
    input  logic               clear_pulse,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic               blank_min,
    output logic               blank_sec
);

    localparam logic [2*DIGIT_W-1:0] MAX_MIN_BCD = to_bcd(MAX_MIN);
    localparam logic [2*DIGIT_W-1:0] MAX_SEC_BCD = to_bcd(MAX_SEC);

    state_t state_q, state_d;
    logic   paused_flag_q, paused_flag_d;
    logic   phase_q, phase_d;
    logic   blank_min_q, blank_min_d;
    logic   blank_sec_q, blank_sec_d;

    logic   in_run, in_adj;
    logic   run_step;
    logic   sec_inc, min_inc;
    logic   sec_at_max, min_at_max;

    // Every decision is taken from the registered state, so a pause press
    // coinciding with a tick still lets that tick count.
    assign in_run = (state_q == ST_RUN);
    assign in_adj = (state_q == ST_ADJUST);

    always_comb begin
        paused_flag_d = paused_flag_q ^ (pause_pulse & ~in_adj);

        state_d = paused_flag_d ? ST_PAUSED : ST_RUN;
        if (adj) begin
            state_d = ST_ADJUST;
        end

        // Phase only advances while already in ADJUST and restarts at 0 on
        // every entry.
        phase_d = 1'b0;
        if (state_d == ST_ADJUST) begin
            phase_d = phase_q ^ (tick_4hz & in_adj);
        end

        // Blanks are registered together with the state so they drop on the
        // very edge that leaves ADJUST.
        blank_min_d = (state_d == ST_ADJUST) & ~sel & phase_d;
        blank_sec_d = (state_d == ST_ADJUST) &  sel & phase_d;
    end

`ifdef STOPWATCH_SATURATE_EN
    assign run_step = in_run & tick_1hz & ~(min_at_max & sec_at_max);
`else
    assign run_step = in_run & tick_1hz;
`endif

    // Clear wins over any increment in the same cycle. In ADJUST the fields
    // are independent: no carry from seconds into minutes.
    assign sec_inc = ~clear_pulse & (run_step | (in_adj & tick_2hz & sel));
    assign min_inc = ~clear_pulse & ((run_step & sec_at_max) |
                                     (in_adj & tick_2hz & ~sel));

    bcd_mod_counter u_sec (
        .clk      (clk_100mhz),
        .rst_n    (rst_n),
        .inc_i    (sec_inc),
        .clr_i    (clear_pulse),
        .max_i    (MAX_SEC_BCD),
        .tens_o   (sec_tens),
        .ones_o   (sec_ones),
        .at_max_o (sec_at_max)
    );

    bcd_mod_counter u_min (
        .clk      (clk_100mhz),
        .rst_n    (rst_n),
        .inc_i    (min_inc),
        .clr_i    (clear_pulse),
        .max_i    (MAX_MIN_BCD),
        .tens_o   (min_tens),
        .ones_o   (min_ones),
        .at_max_o (min_at_max)
    );

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_PAUSED;
            paused_flag_q <= 1'b1;
            phase_q       <= 1'b0;
            blank_min_q   <= 1'b0;
            blank_sec_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            paused_flag_q <= paused_flag_d;
            phase_q       <= phase_d;
            blank_min_q   <= blank_min_d;
            blank_sec_q   <= blank_sec_d;
        end
    end

    assign running   = in_run;
    assign blank_min = blank_min_q;
    assign blank_sec = blank_sec_q;

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
Consumer end of the tick-generator interface. Takes the single-cycle enable pulses produced by the clock divider (1 Hz, 2 Hz, 4 Hz), plus debounced button pulses, and maintains the MM:SS stopwatch value as four BCD digits. Supports run, paused and adjust modes. Feeds the 7-segment display multiplexer, which separately consumes the 500 Hz tick.

Parameters:
MAX_MIN, 59, terminal minute value (BCD-representable, 1..99)
MAX_SEC, 59, terminal second value (BCD-representable, 1..99)

Ports:
clk_100mhz  input  1  system clock; all state changes on its rising edge
rst_n  input  1  asynchronous active-low reset
tick_1hz  input  1  one-cycle enable pulse, counting rate
tick_2hz  input  1  one-cycle enable pulse, adjust increment rate
tick_4hz  input  1  one-cycle enable pulse, adjust blink rate
pause_pulse  input  1  one-cycle debounced pause-button pulse
clear_pulse  input  1  one-cycle debounced clear-button pulse
adj  input  1  level: 1 = adjust mode
sel  input  1  level in adjust mode: 0 = minutes, 1 = seconds
min_tens, min_ones, sec_tens, sec_ones  output  4 each  BCD digits
running  output  1  1 while in RUN
blank_min  output  1  display should blank the minute digits
blank_sec  output  1  display should blank the second digits

Behaviour:
- Reset (rst_n low, asynchronous):
  - all digits 0, state PAUSED, blink phase 0
  - running = 0, blank_min = 0, blank_sec = 0
  - after release, the first action occurs on the first qualifying pulse
- States: RUN, PAUSED, ADJUST. A separate paused_flag register remembers RUN vs PAUSED across ADJUST.
- Next state:
  - adj=1 → ADJUST
  - adj=0 → PAUSED if paused_flag, else RUN
- pause_pulse:
  - toggles paused_flag only while the registered state is not ADJUST
  - ignored in ADJUST
  - the new mode is visible on the next cycle
- RUN, on tick_1hz:
  - seconds +1
  - at MAX_SEC: seconds → 00 and minutes +1
  - at MAX_MIN:MAX_SEC: wraps to 00:00 (see optional feature)
  - tick_2hz and tick_4hz are ignored in RUN
- PAUSED: all ticks ignored; digits hold.
- ADJUST:
  - on tick_2hz, the selected field +1; it wraps MAX→00 with no carry into the other field
  - tick_1hz ignored
  - sel is sampled in the same cycle as the tick
- Blink:
  - phase register toggles on tick_4hz while in ADJUST; forced 0 outside ADJUST
  - blank_min = ADJUST & ~sel & phase
  - blank_sec = ADJUST & sel & phase
- Priority within one cycle: clear_pulse > increment. Clear sets 00:00, leaves state/paused_flag unchanged and suppresses any same-cycle increment.
- Simultaneous pause_pulse and tick_1hz in RUN: the tick counts (decisions use the registered state); the pause takes effect next cycle.
- Leaving ADJUST mid-blink: blanks drop in the same cycle the registered state leaves ADJUST.
- Latency: digits and all outputs are registered and change exactly one cycle after the qualifying pulse. running reflects the registered state.
- Arithmetic: pure BCD per digit; ones digit 9 → 0 with tens +1. Digits never take values 10-15.

Optional Feature:
STOPWATCH_SATURATE_EN
- Defined: in RUN, at MAX_MIN:MAX_SEC further tick_1hz pulses are ignored (holds 59:59). Adjust-mode wrap is unchanged.
- Undefined: wraps to 00:00.

Decomposition:
- Package stopwatch_pkg:
  - state encoding (RUN/PAUSED/ADJUST, 2-bit)
  - BCD digit width constant (4)
  - default limits 59/59
- Sub-module bcd_mod_counter (two-digit BCD counter):
  - inputs: inc, clr, max value
  - outputs: tens/ones digits, registered at_max
  - instantiated once for minutes and once for seconds; the top level gates inc by mode and carry

Test Plan:
- Reset release, RUN via pause_pulse, 61 tick_1hz → 01:01, running=1; each update one cycle after its tick.
- Preload 58:59 via ADJUST, RUN, 61 ticks → 00:00 after 59:59 with macro off; holds 59:59 with STOPWATCH_SATURATE_EN.
- ADJUST sel=1 at 00:58, 3 tick_2hz → 00:59, 00:00, 00:01; minutes stay 00. tick_1hz during ADJUST → no change.
- ADJUST sel=0, tick_4hz ×3 → blank_min sequence 1,0,1; blank_sec stays 0; drop adj → blanks 0 next cycle, mode returns to prior RUN/PAUSED.
- clear_pulse coincident with tick_1hz at 00:09 in RUN → 00:00 and still RUN; pause_pulse coincident with tick at 00:05 → 00:06 then PAUSED.
- rst_n asserted mid-count at 12:34 between clock edges → digits 0 immediately (asynchronous), state PAUSED.
